vram_wr_sched: RTL and testbench

Write-port scheduler for the character generator's 1K×8 VRAM. It merges two write sources onto the single VRAM write port: CPU writes strobed through a register-bus bit, and a hardware fill engine that clears or fills an address range. It sits between the CPU register block and the video core's VRAM write inputs, and can restrict writes to the blanking interval so the display never tears.

---
 rtl/chr_gen_pkg.sv | 14 +
 rtl/vram_wr_fifo.sv | 62 ++++++
 rtl/vram_wr_sched.sv | 151 +++++++++++++++
 tb/tb_vram_wr_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chr_gen_pkg.sv
// Shared definitions for the character generator: VRAM geometry and the
// fill-engine state encoding used by the VRAM write scheduler.
package chr_gen_pkg;

    localparam int C_VRAM_AW = 10;
    localparam int C_VRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO for queued CPU writes. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is flagged as a drop.
module vram_wr_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_b_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok  = pop_i & ~empty_o;
        push_ok = push_i & (~full_o | pop_ok);
        drop_o  = push_i & ~push_ok;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vram_wr_sched.sv
// Merges queued CPU writes and the fill engine onto the single VRAM write port,
// optionally restricting writes to the blanking interval.
module vram_wr_sched
    import chr_gen_pkg::*;
#(
    parameter int C_AW         = C_VRAM_AW,
    parameter int C_DW         = C_VRAM_DW,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic            CK_i,
    input  logic            XSYS_R_i,
    input  logic            CPU_WE_i,
    input  logic [C_AW-1:0] CPU_WAs_i,
    input  logic [C_DW-1:0] CPU_WDs_i,
    input  logic            FILL_START_i,
    input  logic [C_AW-1:0] FILL_BASEs_i,
    input  logic [C_AW:0]   FILL_LENs_i,
    input  logic [C_DW-1:0] FILL_DATs_i,
    input  logic            BLANK_ONLY_i,
    input  logic            BLANK_i,
    output logic [C_AW-1:0] VRAM_WAs_o,
    output logic [C_DW-1:0] VRAM_WDs_o,
    output logic            VRAM_WE_o,
    output logic            FIFO_FULL_o,
    output logic            DROP_o,
    output logic            FILL_BUSY_o,
    output logic            FILL_DONE_o
);

    localparam logic [C_AW:0] ONE_WORD = {{C_AW{1'b0}}, 1'b1};

    logic                 cpu_we_d_q;
    logic                 push;
    logic                 pop;
    logic                 win;
    logic                 fill_issue;
    logic [C_AW+C_DW-1:0] fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_drop;

    fill_state_e          state_q, state_d;
    logic                 start_q, start_d;
    logic [C_AW-1:0]      fill_addr_q, fill_addr_d;
    logic [C_AW:0]        remain_q, remain_d;
    logic [C_DW-1:0]      fill_dat_q, fill_dat_d;
    logic                 done_q, done_d;
    logic                 drop_q;
    logic                 we_q;
    logic [C_AW-1:0]      wa_q;
    logic [C_DW-1:0]      wd_q;

    vram_wr_fifo #(
        .W     (C_AW + C_DW),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CK_i),
        .rst_b_i (XSYS_R_i),
        .push_i  (push),
        .wdata_i ({CPU_WAs_i, CPU_WDs_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    // start_q delays the first fill word by one cycle after the parameters are latched.
    always_comb begin
        win         = ~BLANK_ONLY_i | BLANK_i;
        push        = CPU_WE_i & ~cpu_we_d_q;
        pop         = win & ~fifo_empty;
        fill_issue  = win & fifo_empty & (state_q == FILL);
        state_d     = state_q;
        start_d     = 1'b0;
        fill_addr_d = fill_addr_q;
        remain_d    = remain_q;
        fill_dat_d  = fill_dat_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = FILL;
                end else if (FILL_START_i) begin
                    if (FILL_LENs_i != '0) begin
                        start_d     = 1'b1;
                        fill_addr_d = FILL_BASEs_i;
                        remain_d    = FILL_LENs_i;
                        fill_dat_d  = FILL_DATs_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (fill_issue) begin
                    fill_addr_d = fill_addr_q + 1'b1;
                    remain_d    = remain_q - 1'b1;
                    if (remain_q == ONE_WORD) state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK_i) begin
        if (!XSYS_R_i) begin
            cpu_we_d_q  <= 1'b1;
            state_q     <= IDLE;
            start_q     <= 1'b0;
            fill_addr_q <= '0;
            remain_q    <= '0;
            fill_dat_q  <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
        end else begin
            cpu_we_d_q  <= CPU_WE_i;
            state_q     <= state_d;
            start_q     <= start_d;
            fill_addr_q <= fill_addr_d;
            remain_q    <= remain_d;
            fill_dat_q  <= fill_dat_d;
            done_q      <= done_d;
            drop_q      <= fifo_drop;
            we_q        <= pop | fill_issue;
            if (pop) begin
                wa_q <= fifo_head[C_AW+C_DW-1:C_DW];
                wd_q <= fifo_head[C_DW-1:0];
            end else if (fill_issue) begin
                wa_q <= fill_addr_q;
                wd_q <= fill_dat_q;
            end
        end
    end

    assign VRAM_WE_o   = we_q;
    assign VRAM_WAs_o  = wa_q;
    assign VRAM_WDs_o  = wd_q;
    assign FIFO_FULL_o = fifo_full;
    assign DROP_o      = drop_q;
    assign FILL_DONE_o = done_q;
    assign FILL_BUSY_o = (state_q == FILL) || (state_q == DONE);

endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed and randomized checks of the VRAM write scheduler against a
// queue-based reference model of the merge, fill and blanking rules.
module tb_vram_wr_sched;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cpu_we;
    logic [9:0]  cpu_wa;
    logic [7:0]  cpu_wd;
    logic        fstart;
    logic [9:0]  fbase;
    logic [10:0] flen;
    logic [7:0]  fdat;
    logic        bo;
    logic        blank;
    logic [9:0]  vram_wa;
    logic [7:0]  vram_wd;
    logic        vram_we;
    logic        full;
    logic        drop;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;
    int cycnt       = 0;

    logic [17:0] obs[$];
    int          obs_cyc[$];
    int          drops_obs = 0;
    int          dones_obs = 0;

    // reference model state
    logic [17:0] exp_q[$];
    logic [17:0] mq[$];
    logic        m_prev_we = 1'b1;
    bit          m_wait = 0, m_fill = 0, m_dph = 0;
    int          m_addr = 0, m_rem = 0;
    logic [7:0]  m_dat = '0;
    int          m_drops = 0, m_dones = 0;

    vram_wr_sched dut (
        .CK_i         (clk),
        .XSYS_R_i     (rst_b),
        .CPU_WE_i     (cpu_we),
        .CPU_WAs_i    (cpu_wa),
        .CPU_WDs_i    (cpu_wd),
        .FILL_START_i (fstart),
        .FILL_BASEs_i (fbase),
        .FILL_LENs_i  (flen),
        .FILL_DATs_i  (fdat),
        .BLANK_ONLY_i (bo),
        .BLANK_i      (blank),
        .VRAM_WAs_o   (vram_wa),
        .VRAM_WDs_o   (vram_wd),
        .VRAM_WE_o    (vram_we),
        .FIFO_FULL_o  (full),
        .DROP_o       (drop),
        .FILL_BUSY_o  (busy),
        .FILL_DONE_o  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycnt <= cycnt + 1;

    always @(negedge clk) begin
        if (vram_we) begin
            obs.push_back({vram_wa, vram_wd});
            obs_cyc.push_back(cycnt);
        end
        if (drop) drops_obs++;
        if (done) dones_obs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the model by one clock edge using the inputs the DUT will sample.
    task automatic model_step();
        bit win, idle_pre, fill_pre, dph_pre, rise;
        if (!rst_b) begin
            mq.delete();
            m_prev_we = 1'b1;
            m_wait = 0; m_fill = 0; m_dph = 0;
            return;
        end
        win      = !bo || blank;
        idle_pre = !m_fill && !m_wait && !m_dph;
        fill_pre = m_fill;
        dph_pre  = m_dph;
        if (dph_pre) begin
            m_dones++;
            m_dph = 0;
        end
        if (win && mq.size() > 0) begin
            exp_q.push_back(mq.pop_front());
        end else if (win && fill_pre) begin
            exp_q.push_back({10'(m_addr), m_dat});
            m_addr = (m_addr + 1) % 1024;
            m_rem--;
            if (m_rem == 0) begin
                m_fill = 0;
                m_dph  = 1;
            end
        end
        if (m_wait) begin
            m_wait = 0;
            m_fill = 1;
        end
        if (fstart && idle_pre) begin
            if (flen == 0) begin
                m_dones++;
            end else begin
                m_wait = 1;
                m_addr = int'(fbase);
                m_rem  = int'(flen);
                m_dat  = fdat;
            end
        end
        rise = cpu_we && !m_prev_we;
        m_prev_we = cpu_we;
        if (rise) begin
            if (mq.size() < 4) mq.push_back({cpu_wa, cpu_wd});
            else m_drops++;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            chk({tag, "_word"}, 32'(obs[i]), 32'(exp_q[i]));
        obs.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic clr_counts();
        drops_obs = 0; dones_obs = 0; m_drops = 0; m_dones = 0;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        cpu_we = 1'b1; cpu_wa = a; cpu_wd = d;
        cyc();
        cpu_we = 1'b0;
        cyc();
    endtask

    task automatic start_fill(input logic [9:0] b, input logic [10:0] l, input logic [7:0] d);
        fstart = 1'b1; fbase = b; flen = l; fdat = d;
        cyc();
        fstart = 1'b0;
    endtask

    initial begin
        int k, nfill;
        rst_b = 1'b0; cpu_we = 1'b1; cpu_wa = '0; cpu_wd = '0;
        fstart = 1'b0; fbase = '0; flen = '0; fdat = '0; bo = 1'b0; blank = 1'b0;
        @(negedge clk); #1;
        repeat (3) cyc();

        // reset values
        chk("rst_we",   32'(vram_we), 0);
        chk("rst_wa",   32'(vram_wa), 0);
        chk("rst_wd",   32'(vram_wd), 0);
        chk("rst_drop", 32'(drop),    0);
        chk("rst_busy", 32'(busy),    0);
        chk("rst_done", 32'(done),    0);
        chk("rst_full", 32'(full),    0);

        // strobe held high across reset release must not write
        rst_b = 1'b1;
        repeat (3) cyc();
        cpu_we = 1'b0;
        repeat (2) cyc();
        chk("held_we_writes", 32'(obs.size()), 0);
        check_log("held_we");

        // single CPU write, two edges of latency
        cpu_we = 1'b1; cpu_wa = 10'h123; cpu_wd = 8'h5A;
        cyc();
        chk("single_lat_early", 32'(vram_we), 0);
        cpu_we = 1'b0;
        cyc();
        chk("single_we", 32'(vram_we), 1);
        chk("single_wa", 32'(vram_wa), 32'h123);
        chk("single_wd", 32'(vram_wd), 32'h5A);
        repeat (3) cyc();
        chk("single_count", 32'(obs.size()), 1);
        check_log("single");

        // overflow while writes are held off
        clr_counts();
        bo = 1'b1; blank = 1'b0;
        for (int i = 0; i < 6; i++) cpu_write(10'(10'h40 + i), 8'(8'hA0 + i));
        cyc();
        chk("ovf_full",  32'(full), 1);
        chk("ovf_drops", 32'(drops_obs), 2);
        chk("ovf_drops_model", 32'(drops_obs), 32'(m_drops));
        chk("ovf_held",  32'(obs.size()), 0);
        blank = 1'b1;
        repeat (6) cyc();
        chk("ovf_drain_full", 32'(full), 0);
        chk("ovf_drain_count", 32'(obs.size()), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++)
            chk("ovf_drain_order", 32'(obs[i]), 32'({10'(10'h40 + i), 8'(8'hA0 + i)}));
        check_log("ovf");
        bo = 1'b0; blank = 1'b0;

        // fill with address wrap
        clr_counts();
        k = cycnt + 1;
        start_fill(10'd1022, 11'd4, 8'h20);
        repeat (8) cyc();
        chk("wrap_count", 32'(obs.size()), 4);
        if (obs.size() == 4) begin
            chk("wrap_w0", 32'(obs[0]), 32'({10'd1022, 8'h20}));
            chk("wrap_w1", 32'(obs[1]), 32'({10'd1023, 8'h20}));
            chk("wrap_w2", 32'(obs[2]), 32'({10'd0,    8'h20}));
            chk("wrap_w3", 32'(obs[3]), 32'({10'd1,    8'h20}));
            chk("wrap_first_lat", 32'(obs_cyc[0]), 32'(k + 2));
            chk("wrap_back2back", 32'(obs_cyc[3] - obs_cyc[0]), 3);
        end
        chk("wrap_done", 32'(dones_obs), 1);
        chk("wrap_busy", 32'(busy), 0);
        check_log("wrap");

        // contention: CPU words jump ahead of fill words
        clr_counts();
        start_fill(10'h200, 11'd16, 8'h77);
        repeat (4) cyc();
        cpu_write(10'h3AA, 8'h11);
        cyc();
        cpu_write(10'h3BB, 8'h22);
        repeat (25) cyc();
        chk("cont_total", 32'(obs.size()), 18);
        nfill = 0;
        foreach (obs[i]) begin
            if (obs[i][7:0] == 8'h77) begin
                chk("cont_fill_addr", 32'(obs[i][17:8]), 32'(32'h200 + nfill));
                nfill++;
            end
        end
        chk("cont_fill_words", 32'(nfill), 16);
        chk("cont_done", 32'(dones_obs), 1);
        check_log("cont");

        // zero-length fill
        clr_counts();
        start_fill(10'h055, 11'd0, 8'hEE);
        repeat (4) cyc();
        chk("len0_done", 32'(dones_obs), 1);
        chk("len0_writes", 32'(obs.size()), 0);
        chk("len0_busy", 32'(busy), 0);
        check_log("len0");

        // start during a running fill is ignored
        clr_counts();
        start_fill(10'h010, 11'd6, 8'h33);
        repeat (2) cyc();
        start_fill(10'h300, 11'd3, 8'h44);
        repeat (12) cyc();
        chk("ign_count", 32'(obs.size()), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++)
            chk("ign_word", 32'(obs[i]), 32'({10'(10'h010 + i), 8'h33}));
        chk("ign_done", 32'(dones_obs), 1);
        check_log("ign");

        // reset in the middle of a fill
        clr_counts();
        start_fill(10'h080, 11'd10, 8'h55);
        for (int t = 0; t < 20 && obs.size() < 5; t++) cyc();
        chk("rstfill_reach5", 32'(obs.size()), 5);
        rst_b = 1'b0;
        cyc();
        rst_b = 1'b1;
        chk("rstfill_we",   32'(vram_we), 0);
        chk("rstfill_busy", 32'(busy),    0);
        chk("rstfill_full", 32'(full),    0);
        repeat (15) cyc();
        chk("rstfill_nodone", 32'(dones_obs), 0);
        chk("rstfill_nowrites", 32'(obs.size()), 5);
        check_log("rstfill");

        // randomized traffic against the model
        clr_counts();
        for (int n = 0; n < 400; n++) begin
            bo     = (n < 200) ? 1'b1 : 1'($urandom_range(0, 1));
            blank  = ($urandom_range(0, 3) != 0);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_wa = 10'($urandom);
            cpu_wd = 8'($urandom);
            fstart = ($urandom_range(0, 30) == 0);
            fbase  = 10'($urandom);
            flen   = 11'($urandom_range(0, 20));
            fdat   = 8'($urandom);
            cyc();
        end
        fstart = 1'b0; cpu_we = 1'b0; blank = 1'b1;
        repeat (60) cyc();
        chk("rand_drops", 32'(drops_obs), 32'(m_drops));
        chk("rand_dones", 32'(dones_obs), 32'(m_dones));
        chk("rand_busy",  32'(busy), 0);
        check_log("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
